uart_rx_byte: RTL and testbench

- UART receiver for the single-cycle CPU's serial peripheral. It is the receive end of the link whose transmit side drives UART_TX.
- Deserialises 8N1 frames from the UART_RX pin using 16x oversampling.
- Holds the received byte and status flags for the CPU's memory-mapped UART read path, which polls rx_ready and acknowledges with rx_ack.

---
 rtl/uart_rx_byte.sv | 180 ++++++++++++++++++
 tb/tb_uart_rx_byte.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 16x-oversampled UART receiver for the CPU serial peripheral.
// Holds the last byte plus sticky status flags for the memory-mapped read path.
// Optional 8E1 framing is enabled by defining UART_RX_PARITY_EN; by default the
// receiver decodes 8N1 frames and parity_err stays 0.
module uart_rx_byte #(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       UART_RX,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_ready,
    output logic       overrun,
    output logic       frame_err,
    output logic       parity_err
);

    localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t        state;
    logic          rx_meta;
    logic          rxs;
    logic [CW-1:0] cnt;
    logic          tick;
    logic          start_go;
    logic [3:0]    s;
    logic [2:0]    n;
    logic [7:0]    shreg;
    logic          deliver;

    assign tick     = (cnt == DIV_LAST);
    assign start_go = (state == S_IDLE) && !rxs;

    // Two-flop synchroniser for the asynchronous serial pin, idle high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= UART_RX;
            rxs     <= rx_meta;
        end
    end

    // Oversample tick divider, re-phased to the start edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (start_go || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Frame decoder and host-facing status registers.
    // Flag clears from rx_ack come first so a flag set in the same cycle wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            s          <= '0;
            n          <= '0;
            shreg      <= '0;
            deliver    <= 1'b0;
            rx_data    <= '0;
            rx_ready   <= 1'b0;
            overrun    <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            deliver <= 1'b0;

            if (deliver) begin
                rx_data  <= shreg;
                rx_ready <= 1'b1;
                if (rx_ack) begin
                    frame_err  <= 1'b0;
                    parity_err <= 1'b0;
                end else if (rx_ready) begin
                    overrun <= 1'b1;
                end
            end else if (rx_ack) begin
                rx_ready   <= 1'b0;
                overrun    <= 1'b0;
                frame_err  <= 1'b0;
                parity_err <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (!rxs) begin
                        s     <= '0;
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (tick) begin
                        if (s == 4'd7) begin
                            if (rxs) begin
                                state <= S_IDLE;
                            end else begin
                                s     <= '0;
                                n     <= '0;
                                state <= S_DATA;
                            end
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        s <= s + 1'b1;
                        if (s == 4'd15) begin
                            shreg[n] <= rxs;
                            n        <= n + 1'b1;
                            if (n == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                                state <= S_PARITY;
`else
                                state <= S_STOP;
`endif
                            end
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (tick) begin
                        s <= s + 1'b1;
                        if (s == 4'd15) begin
                            if (^{shreg, rxs}) begin
                                parity_err <= 1'b1;
                            end
                            state <= S_STOP;
                        end
                    end
                end
`endif
                S_STOP: begin
                    if (tick) begin
                        s <= s + 1'b1;
                        if (s == 4'd15) begin
                            if (rxs) begin
                                deliver <= 1'b1;
                                state   <= S_IDLE;
                            end else begin
                                frame_err <= 1'b1;
                                state     <= S_WAIT_IDLE;
                            end
                        end
                    end
                end
                S_WAIT_IDLE: begin
                    if (rxs) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed plus randomized bench for uart_rx_byte at DIV=10 (160 clocks/bit).
// Define UART_RX_PARITY_EN to exercise the 8E1 build.
module tb_uart_rx_byte;

`ifdef UART_RX_PARITY_EN
    localparam bit PAR = 1'b1;
    localparam int PO  = 160;
`else
    localparam bit PAR = 1'b0;
    localparam int PO  = 0;
`endif
    localparam int BIT = 160;
    localparam int NB  = PAR ? 11 : 10;
    // Delivery edge offset from the start-edge drive: 2 sync clocks,
    // 1 clock to leave IDLE, 9.5 bits to the stop centre, 1 clock to deliver.
    localparam int DELIV = 1523 + PO;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       UART_RX = 1'b1;
    logic       rx_ack = 1'b0;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       overrun;
    logic       frame_err;
    logic       parity_err;

    int total = 0;
    int bad   = 0;

    logic [7:0] m_data  = 8'h00;
    logic       m_ready = 1'b0;
    logic       m_ovr   = 1'b0;
    logic       m_ferr  = 1'b0;
    logic       m_perr  = 1'b0;

    uart_rx_byte #(.CLK_FREQ(1600000), .BAUD(10000), .OVERSAMPLE(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .UART_RX   (UART_RX),
        .rx_ack    (rx_ack),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .overrun   (overrun),
        .frame_err (frame_err),
        .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".data"},  rx_data,    m_data);
        chk({tag, ".ready"}, rx_ready,   m_ready);
        chk({tag, ".ovr"},   overrun,    m_ovr);
        chk({tag, ".ferr"},  frame_err,  m_ferr);
        chk({tag, ".perr"},  parity_err, m_perr);
    endtask

    task automatic model_clear_flags();
        m_ready = 1'b0;
        m_ovr   = 1'b0;
        m_ferr  = 1'b0;
        m_perr  = 1'b0;
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) @(negedge clk);
    endtask

    task automatic ack();
        @(negedge clk);
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
        model_clear_flags();
    endtask

    // Frame-level model: what the host sees once a whole frame has gone by.
    task automatic model_frame(input logic [7:0] b, input logic stop, input logic par_ok,
                               input logic ack_in);
        if (PAR && !par_ok) m_perr = 1'b1;
        if (stop) begin
            if (ack_in) begin
                m_ferr = 1'b0;
                m_perr = 1'b0;
            end else if (m_ready) begin
                m_ovr = 1'b1;
            end
            m_data  = b;
            m_ready = 1'b1;
        end else begin
            m_ferr = 1'b1;
        end
    endtask

    // Drives one frame, one negedge per clock. ack_k/rst_k < 0 disable those events.
    task automatic send_frame(input logic [7:0] b, input logic stop, input logic par_ok,
                              input int ack_k, input int rst_k, input int extra_low,
                              output int rise_k);
        logic pbit;
        int   i;
        pbit   = par_ok ? ^b : ~(^b);
        rise_k = -1;
        for (int k = 0; k < NB * BIT + extra_low; k++) begin
            @(negedge clk);
            if (rise_k < 0 && rx_ready === 1'b1) rise_k = k;
            if (rst_k >= 0) begin
                if (k == rst_k) begin
                    reset  = 1'b0;
                    m_data = 8'h00;
                    model_clear_flags();
                end
                if (k == rst_k + 1) check_all("reset_mid");
                if (k == rst_k + 3) reset = 1'b1;
            end
            i = k / BIT;
            if (i == 0)                 UART_RX = 1'b0;
            else if (i <= 8)            UART_RX = b[i-1];
            else if (PAR && i == 9)     UART_RX = pbit;
            else if (i < NB)            UART_RX = stop;
            else                        UART_RX = 1'b0;
            rx_ack = (k == ack_k);
        end
        @(negedge clk);
        UART_RX = 1'b1;
        rx_ack  = 1'b0;
    endtask

    initial begin
        int         rk;
        logic [7:0] b;
        logic       stop;
        logic       pok;
        logic       ain;

        // Reset state
        idle(5);
        check_all("reset");
        reset = 1'b1;
        idle(20);
        check_all("post_reset");

        // 1: valid frame 0xA5 and its latency
        send_frame(8'hA5, 1'b1, 1'b1, -1, -1, 0, rk);
        model_frame(8'hA5, 1'b1, 1'b1, 1'b0);
        check_all("t1_frame");
        total++;
        assert (rk >= 1441 + PO && rk <= 1525 + PO) else begin
            bad++;
            $error("FAIL t1_latency: observed=%0d expected=%0d..%0d", rk, 1441 + PO, 1525 + PO);
        end
        ack();
        idle(2);
        check_all("t1_ack");

        // 2: 40-clock glitch, then a real frame
        idle(50);
        @(negedge clk);
        UART_RX = 1'b0;
        idle(40);
        UART_RX = 1'b1;
        idle(300);
        check_all("t2_glitch");
        send_frame(8'h3C, 1'b1, 1'b1, -1, -1, 0, rk);
        model_frame(8'h3C, 1'b1, 1'b1, 1'b0);
        check_all("t2_frame");
        ack();

        // 3: bad stop bit with a 5-bit break, then a good frame
        idle(50);
        send_frame(8'h3C, 1'b0, 1'b1, -1, -1, 5 * BIT, rk);
        model_frame(8'h3C, 1'b0, 1'b1, 1'b0);
        check_all("t3_break");
        idle(200);
        send_frame(8'h81, 1'b1, 1'b1, -1, -1, 0, rk);
        model_frame(8'h81, 1'b1, 1'b1, 1'b0);
        check_all("t3_frame");
        ack();
        idle(2);
        check_all("t3_ack");

        // 4: overrun, then ack coinciding with delivery
        idle(50);
        send_frame(8'h11, 1'b1, 1'b1, -1, -1, 0, rk);
        model_frame(8'h11, 1'b1, 1'b1, 1'b0);
        idle(50);
        send_frame(8'h22, 1'b1, 1'b1, -1, -1, 0, rk);
        model_frame(8'h22, 1'b1, 1'b1, 1'b0);
        check_all("t4_overrun");
        ack();
        idle(2);
        check_all("t4_ack");
        idle(50);
        send_frame(8'h11, 1'b1, 1'b1, -1, -1, 0, rk);
        model_frame(8'h11, 1'b1, 1'b1, 1'b0);
        idle(50);
        send_frame(8'h22, 1'b1, 1'b1, DELIV, -1, 0, rk);
        model_frame(8'h22, 1'b1, 1'b1, 1'b1);
        check_all("t4_ack_deliv");

        // 5: reset during data bit 3, then recovery
        idle(50);
        send_frame(8'h77, 1'b1, 1'b1, -1, 700, 0, rk);
        check_all("t5_aborted");
        idle(3000);
        ack();
        send_frame(8'h5A, 1'b1, 1'b1, -1, -1, 0, rk);
        model_frame(8'h5A, 1'b1, 1'b1, 1'b0);
        check_all("t5_frame");
        ack();

`ifdef UART_RX_PARITY_EN
        // 6: even parity good and bad
        idle(50);
        send_frame(8'h07, 1'b1, 1'b1, -1, -1, 0, rk);
        model_frame(8'h07, 1'b1, 1'b1, 1'b0);
        check_all("t6_par_ok");
        ack();
        idle(50);
        send_frame(8'h07, 1'b1, 1'b0, -1, -1, 0, rk);
        model_frame(8'h07, 1'b1, 1'b0, 1'b0);
        check_all("t6_par_bad");
        ack();
`endif

        // Randomized frames against the frame-level model
        for (int r = 0; r < 10; r++) begin
            b    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            pok  = ($urandom_range(0, 3) != 0);
            ain  = stop && ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 1) ack();
            idle(200);
            send_frame(b, stop, pok, ain ? DELIV : -1, -1, 0, rk);
            model_frame(b, stop, pok, ain);
            check_all("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
